// File: rtl/mem_byte_access_sequencer.sv
// Turns one byte/halfword/word load or store into little-endian single-byte
// memory cycles on a byte-wide data memory, rejecting misaligned or out-of-range requests.
module mem_byte_access_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              req_in,
    input  logic              we_req_in,
    input  logic [1:0]        size_in,
    input  logic [ADDR_W-1:0] addr_req_in,
    input  logic [31:0]       wdata_in,
    output logic              ready_out,
    output logic              done_out,
    output logic              err_out,
    output logic [31:0]       rdata_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we_out,
    output logic [7:0]        mem_wd_out,
    input  logic [7:0]        mem_rd_in,
    output logic [1:0]        dbg_state_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_k;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_last_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_busy;
    logic              w_req_err;
    logic [2:0]        w_req_n;
    logic [ADDR_W:0]   w_req_end;
    logic [1:0]        w_last_k;
    logic [ADDR_W-1:0] w_cur_addr;

    // Handshake: a request transfers on a posedge where req_in and ready_out are both 1;
    // ready_out is high only in IDLE out of reset, so req_in is ignored in BUSY and DONE.
    assign ready_out = reset_in & (r_state == ST_IDLE);
    assign w_accept  = req_in & ready_out;
    assign w_busy    = (r_state == ST_BUSY);

    always_comb begin
        w_req_n = 3'd4;
        case (size_in)
            2'd0:    w_req_n = 3'd1;
            2'd1:    w_req_n = 3'd2;
            default: w_req_n = 3'd4;
        endcase
    end

    // End address is computed one bit wider so a request near the top of the address space cannot wrap.
    assign w_req_end = {1'b0, addr_req_in} + (ADDR_W + 1)'(w_req_n);
    assign w_req_err = (size_in == 2'd3)
                     | ((size_in == 2'd1) & addr_req_in[0])
                     | ((size_in == 2'd2) & (addr_req_in[1:0] != 2'b00))
                     | (w_req_end > DEPTH_LIM);

    always_comb begin
        w_last_k = 2'd3;
        case (r_size)
            2'd0:    w_last_k = 2'd0;
            2'd1:    w_last_k = 2'd1;
            default: w_last_k = 2'd3;
        endcase
    end

    assign w_cur_addr = r_base + ADDR_W'(r_k);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_err ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_k == w_last_k) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_out = r_last_addr;
        mem_we_out   = 1'b0;
        mem_wd_out   = 8'h00;
        if (w_busy) begin
            mem_addr_out = w_cur_addr;
            mem_we_out   = reset_in & r_we;
            if (r_we) begin
                mem_wd_out = r_wdata[{r_k, 3'b000} +: 8];
            end
        end
    end

    assign done_out      = reset_in & (r_state == ST_DONE);
    assign err_out       = r_err;
    assign rdata_out     = r_rdata;
    assign dbg_state_out = r_state;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state     <= ST_IDLE;
            r_k         <= 2'd0;
            r_size      <= 2'd0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_base      <= '0;
            r_last_addr <= '0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= we_req_in;
                r_size  <= size_in;
                r_base  <= addr_req_in;
                r_wdata <= wdata_in;
                r_rdata <= 32'h0;
                r_err   <= w_req_err;
                r_k     <= 2'd0;
            end else if (w_busy) begin
                r_last_addr <= w_cur_addr;
                if (!r_we) begin
                    r_rdata[{r_k, 3'b000} +: 8] <= mem_rd_in;
                end
                r_k <= r_k + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_access_sequencer.sv
// Bench for mem_byte_access_sequencer: byte memory, transaction-level reference
// model checked every cycle, directed cases with literal expectations, random traffic.
module tb_mem_byte_access_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_in;
    logic        we_req_in;
    logic [1:0]  size_in;
    logic [31:0] addr_req_in;
    logic [31:0] wdata_in;
    logic        ready_out;
    logic        done_out;
    logic        err_out;
    logic [31:0] rdata_out;
    logic [31:0] mem_addr_out;
    logic        mem_we_out;
    logic [7:0]  mem_wd_out;
    logic [7:0]  mem_rd_in;
    logic [1:0]  dbg_state_out;

    mem_byte_access_sequencer #(.ADDR_W(32), .MEM_DEPTH(256)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in), .we_req_in(we_req_in),
        .size_in(size_in), .addr_req_in(addr_req_in), .wdata_in(wdata_in),
        .ready_out(ready_out), .done_out(done_out), .err_out(err_out), .rdata_out(rdata_out),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_wd_out(mem_wd_out),
        .mem_rd_in(mem_rd_in), .dbg_state_out(dbg_state_out)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- attached byte memory ----------------
    logic [7:0] mem [256];
    assign mem_rd_in = mem[mem_addr_out[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        forever begin
            @(posedge clk_in);
            if (mem_we_out) mem[mem_addr_out[7:0]] <= mem_wd_out;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    int we_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction described by its accept cycle.
    logic [7:0]  ref_mem [256];
    bit          chk_en = 0;
    bit          pending = 0;
    int          p_c, p_n;
    logic        p_err, p_we;
    logic [31:0] p_base, p_wd, p_rdata;
    logic [31:0] exp_rdata = 0;
    logic        exp_err = 0;
    logic [31:0] exp_last = 0;

    task automatic apply_store(input int nbytes);
        for (int i = 0; i < nbytes; i++) ref_mem[(p_base + 32'(i)) & 32'hFF] = 8'(p_wd >> (8 * i));
    endtask

    initial begin
        logic        e_ready, e_done, e_busy, e_we;
        logic [31:0] e_addr;
        int          lat, k, nb;
        longint      end_addr;
        #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        forever begin
            @(negedge clk_in);
            lat     = p_err ? 1 : p_n + 1;
            k       = cyc - p_c - 1;
            e_ready = reset_in && !pending;
            e_done  = reset_in && pending && (cyc == p_c + lat);
            e_busy  = pending && !p_err && (cyc >= p_c + 1) && (cyc <= p_c + p_n);
            e_we    = reset_in && e_busy && p_we;
            e_addr  = e_busy ? p_base + 32'(k) : exp_last;
            if (chk_en) begin
                if (mem_we_out) we_total++;
                chk("ready_out", 32'(ready_out), 32'(e_ready));
                chk("done_out", 32'(done_out), 32'(e_done));
                chk("mem_we_out", 32'(mem_we_out), 32'(e_we));
                chk("mem_addr_out", mem_addr_out, e_addr);
                if (e_we) chk("mem_wd_out", 32'(mem_wd_out), 32'(8'(p_wd >> (8 * k))));
                if (!e_busy) chk("mem_wd_idle", 32'(mem_wd_out), 32'h0);
                if (e_done) begin
                    chk("done_rdata", rdata_out, p_rdata);
                    chk("done_err", 32'(err_out), 32'(p_err));
                end else if (!pending) begin
                    chk("held_rdata", rdata_out, exp_rdata);
                    chk("held_err", 32'(err_out), 32'(exp_err));
                end
            end
            if (!reset_in) begin
                if (pending && p_we && !p_err) begin
                    nb = cyc - p_c - 1;
                    apply_store(nb < p_n ? nb : p_n);
                end
                pending   = 0;
                exp_rdata = 0;
                exp_err   = 0;
                exp_last  = 0;
                chk_en    = 1;
            end else begin
                if (e_busy) exp_last = e_addr;
                if (e_done) begin
                    if (p_we && !p_err) apply_store(p_n);
                    exp_rdata = p_rdata;
                    exp_err   = p_err;
                    pending   = 0;
                end else if (e_ready && req_in) begin
                    pending  = 1;
                    p_c      = cyc;
                    p_we     = we_req_in;
                    p_base   = addr_req_in;
                    p_wd     = wdata_in;
                    p_n      = (size_in == 0) ? 1 : (size_in == 1) ? 2 : 4;
                    end_addr = longint'(addr_req_in) + longint'(p_n);
                    p_err    = (size_in == 3) || (size_in == 1 && addr_req_in[0])
                            || (size_in == 2 && addr_req_in[1:0] != 0) || (end_addr > 256);
                    p_rdata  = 0;
                    if (!p_we && !p_err)
                        for (int i = 0; i < p_n; i++)
                            p_rdata = p_rdata | (32'(ref_mem[(addr_req_in + 32'(i)) & 32'hFF]) << (8 * i));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int nwe);
        int req_cyc, we0;
        bit got;
        lat = -1; rd = 32'hx; er = 1'bx; nwe = -1;
        req_in = 1; we_req_in = we; size_in = sz; addr_req_in = addr; wdata_in = wd;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_in);
            if (ready_out) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_in = 0;
            return;
        end
        req_cyc = cyc;
        we0 = we_total;
        @(posedge clk_in); #1;
        req_in = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_in);
            if (done_out) begin
                got = 1; lat = cyc - req_cyc; rd = rdata_out; er = err_out;
                nwe = we_total - we0;
            end
        end
        if (!got) chk("done_timeout", 32'd1, 32'd0);
        @(posedge clk_in); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat, nwe, c1, c2, d1;
        logic [31:0] rd;
        logic        er;
        logic [7:0]  old22, old23;
        logic [1:0]  sz;
        logic [31:0] a;
        bit          seen;

        reset_in = 0; req_in = 0; we_req_in = 0; size_in = 0; addr_req_in = 0; wdata_in = 0;
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1;
        @(negedge clk_in);
        chk("reset_ready", 32'(ready_out), 32'd1);
        chk("reset_done", 32'(done_out), 32'd0);
        chk("reset_rdata", rdata_out, 32'h0);
        chk("reset_we", 32'(mem_we_out), 32'd0);
        @(posedge clk_in); #1;

        run_req(1, 2, 32'h10, 32'hA1B2C3D4, lat, rd, er, nwe);
        chk("str_w_lat", 32'(lat), 32'd5);
        chk("str_w_err", 32'(er), 32'd0);
        chk("str_w_nwe", 32'(nwe), 32'd4);
        chk("str_w_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hA1B2C3D4);
        run_req(0, 2, 32'h10, 32'h0, lat, rd, er, nwe);
        chk("ldr_w_rdata", rd, 32'hA1B2C3D4);
        chk("ldr_w_lat", 32'(lat), 32'd5);

        run_req(1, 0, 32'h13, 32'hFFFFFF5E, lat, rd, er, nwe);
        chk("strb_lat", 32'(lat), 32'd2);
        chk("strb_nwe", 32'(nwe), 32'd1);
        chk("strb_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h5EB2C3D4);
        run_req(0, 1, 32'h12, 32'h0, lat, rd, er, nwe);
        chk("ldrh_rdata", rd, 32'h00005EB2);
        chk("ldrh_lat", 32'(lat), 32'd3);

        run_req(0, 2, 32'h11, 32'h0, lat, rd, er, nwe);
        chk("rej_w_err", 32'(er), 32'd1);
        chk("rej_w_lat", 32'(lat), 32'd1);
        chk("rej_w_rdata", rd, 32'h0);
        run_req(1, 1, 32'h13, 32'hFFFF, lat, rd, er, nwe);
        chk("rej_h_err", 32'(er), 32'd1);
        chk("rej_h_nwe", 32'(nwe), 32'd0);
        run_req(1, 3, 32'h10, 32'h12345678, lat, rd, er, nwe);
        chk("rej_sz3_err", 32'(er), 32'd1);
        chk("rej_sz3_nwe", 32'(nwe), 32'd0);
        chk("rej_sz3_lat", 32'(lat), 32'd1);
        run_req(0, 2, 32'hFC, 32'h0, lat, rd, er, nwe);
        chk("top_ok_err", 32'(er), 32'd0);
        chk("top_ok_lat", 32'(lat), 32'd5);
        run_req(0, 2, 32'h100, 32'h0, lat, rd, er, nwe);
        chk("top_rej_err", 32'(er), 32'd1);
        chk("top_rej_rdata", rd, 32'h0);

        // Two queued loads with req_in held high throughout.
        req_in = 1; we_req_in = 0; size_in = 0; addr_req_in = 32'h10; wdata_in = 0;
        c1 = -1; c2 = -1; d1 = -1;
        for (int i = 0; i < 20 && c1 < 0; i++) begin @(negedge clk_in); if (ready_out) c1 = cyc; end
        @(posedge clk_in); #1;
        size_in = 1;
        for (int i = 0; i < 20 && d1 < 0; i++) begin
            @(negedge clk_in);
            if (done_out) begin d1 = cyc; chk("hs_first_rdata", rdata_out, 32'h000000D4); end
        end
        for (int i = 0; i < 20 && c2 < 0; i++) begin @(negedge clk_in); if (ready_out) c2 = cyc; end
        chk("hs_first_lat", 32'(d1 - c1), 32'd2);
        chk("hs_gap", 32'(c2 - d1), 32'd1);
        @(posedge clk_in); #1;
        req_in = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_in);
            if (done_out) begin seen = 1; chk("hs_second_rdata", rdata_out, 32'h0000C3D4); end
        end
        chk("hs_second_done", 32'(seen), 32'd1);
        @(posedge clk_in); #1;

        // Reset during the third byte of a word store.
        old22 = mem[8'h22]; old23 = mem[8'h23];
        req_in = 1; we_req_in = 1; size_in = 2; addr_req_in = 32'h20; wdata_in = 32'h11223344;
        @(negedge clk_in);
        chk("mid_accept_ready", 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;
        req_in = 0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        reset_in = 0;
        @(posedge clk_in); #1;
        reset_in = 1;
        @(negedge clk_in);
        chk("mid_ready", 32'(ready_out), 32'd1);
        chk("mid_done", 32'(done_out), 32'd0);
        chk("mid_mem_lo", {16'h0, mem[8'h21], mem[8'h20]}, 32'h00003344);
        chk("mid_mem_hi", {16'h0, old23, old22}, {16'h0, mem[8'h23], mem[8'h22]});
        @(posedge clk_in); #1;

        // Random traffic; the per-cycle model does the checking.
        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = (sz == 1) ? (a & ~32'h1) : (sz == 2) ? (a & ~32'h3) : a;
            case ($urandom_range(0, 9))
                0: a = 32'($urandom_range(248, 263));
                1: a = $urandom;
                default: ;
            endcase
            run_req(1'($urandom_range(0, 1)), sz, a, $urandom, lat, rd, er, nwe);
            repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
        end

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("mem_image", 32'(bad), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
